store_bus_bridge: RTL

- Memory-stage store unit; store-side counterpart of the load data extender.
- Validates a store (alignment, address map, device rules, address overflow) and raises AdES on violation.
- Encodes legal stores into word address + byte enables + lane-replicated data, latches them in a one-entry buffer, and drives the data bus with a req/ack handshake.
- Stalls the pipeline while the buffer is occupied and not being acknowledged.

---
 rtl/store_bus_bridge.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/store_bus_bridge.sv
// Memory-stage store unit: checks a store, encodes it into word address, byte enables and
// lane-replicated data, buffers it and drives the data bus. Optional macro: STORE_ACK_TIMEOUT_EN.
module store_bus_bridge #(
  parameter logic [31:0] DM_TOP   = 32'h0000_2fff,
  parameter logic [31:0] TC0_BASE = 32'h0000_7f00,
  parameter logic [31:0] TC1_BASE = 32'h0000_7f10,
  parameter logic [31:0] INT_BASE = 32'h0000_7f20,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [2:0]  store_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        M_DM_ov,
  output logic        M_AdES,
  output logic        st_stall,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  output logic [1:0]  bus_sel,
  input  logic        bus_ack,
  output logic        bus_err
);

  localparam logic [31:0] TC_WIN   = 32'd12;
  localparam logic [31:0] INT_WIN  = 32'd4;
  localparam logic [31:0] TC_RO_OFF = 32'd8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_nxt, wdata_nxt;
  logic [3:0]  be_nxt;
  logic [1:0]  sel_nxt;

  logic        is_st, is_sh, is_sb, is_sw;
  logic [31:0] off_tc0, off_tc1, off_int;
  logic        in_dm, in_tc0, in_tc1, in_int;
  logic        align_err, range_err, dev_err;
  logic        accept, timeout_hit;
  logic [3:0]  enc_be;
  logic [31:0] enc_data;
  logic [1:0]  enc_sel;

  // Store decode and address-map checks
  always_comb begin
    is_st   = st_valid && (store_type != 3'b111);
    is_sh   = (store_type == 3'b100);
    is_sb   = (store_type == 3'b010);
    is_sw   = !is_sh && !is_sb;
    off_tc0 = addr - TC0_BASE;
    off_tc1 = addr - TC1_BASE;
    off_int = addr - INT_BASE;
    in_dm   = (addr <= DM_TOP);
    in_tc0  = (off_tc0 < TC_WIN);
    in_tc1  = (off_tc1 < TC_WIN);
    in_int  = (off_int < INT_WIN);
    align_err = (is_sw && (addr[1:0] != 2'b00)) || (is_sh && addr[0]);
    range_err = !(in_dm || in_tc0 || in_tc1 || in_int);
    // Timers take only full words, and their count register is read-only
    dev_err = ((is_sh || is_sb) && (in_tc0 || in_tc1))
           || (in_tc0 && (off_tc0 >= TC_RO_OFF))
           || (in_tc1 && (off_tc1 >= TC_RO_OFF));
    M_AdES  = is_st && (align_err || range_err || dev_err || M_DM_ov);
  end

  // Byte-enable, data-lane and target encoding
  always_comb begin
    enc_be   = 4'b1111;
    enc_data = wdata;
    if (is_sh) begin
      enc_be   = addr[1] ? 4'b1100 : 4'b0011;
      enc_data = {2{wdata[15:0]}};
    end else if (is_sb) begin
      enc_be   = 4'b0001 << addr[1:0];
      enc_data = {4{wdata[7:0]}};
    end
    enc_sel = 2'b00;
    if (in_tc0)      enc_sel = 2'b01;
    else if (in_tc1) enc_sel = 2'b10;
    else if (in_int) enc_sel = 2'b11;
  end

`ifdef STORE_ACK_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] wait_cnt;

  assign timeout_hit = (state == BUSY) && !bus_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign bus_err     = timeout_hit;

  // Counts BUSY cycles without ack; restarts with each newly buffered store
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          wait_cnt <= '0;
    else if (accept)                    wait_cnt <= '0;
    else if (state == BUSY && !bus_ack) wait_cnt <= wait_cnt + CNT_W'(1);
  end
`else
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0 & (TIMEOUT > 0);
`endif

  assign accept   = is_st && !M_AdES && ((state == IDLE) || bus_ack || timeout_hit);
  assign st_stall = is_st && (state == BUSY) && !bus_ack && !timeout_hit;
  assign bus_req  = (state == BUSY);

  // Next state and buffer contents; the buffer reads as zero whenever IDLE
  always_comb begin
    state_nxt = state;
    addr_nxt  = bus_addr;
    be_nxt    = bus_be;
    wdata_nxt = bus_wdata;
    sel_nxt   = bus_sel;
    if (accept) begin
      state_nxt = BUSY;
      addr_nxt  = {addr[31:2], 2'b00};
      be_nxt    = enc_be;
      wdata_nxt = enc_data;
      sel_nxt   = enc_sel;
    end else if ((state == BUSY) && (bus_ack || timeout_hit)) begin
      state_nxt = IDLE;
      addr_nxt  = '0;
      be_nxt    = '0;
      wdata_nxt = '0;
      sel_nxt   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      bus_sel   <= '0;
    end else begin
      state     <= state_nxt;
      bus_addr  <= addr_nxt;
      bus_be    <= be_nxt;
      bus_wdata <= wdata_nxt;
      bus_sel   <= sel_nxt;
    end
  end

endmodule
